// File: rtl/fp_add_front_end_if.sv
// fp_add_front_end_if: operand/result bundle for the binary32 adder front end.
//   master modport: drives in_valid/A/B, receives the registered results.
//   slave modport : receives in_valid/A/B, drives out_valid, exponent_out,
//                   aligned_result, carry_out, aligned_sign and the two
//                   aligned mantissas.
interface fp_add_front_end_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic [EXP_W+MAN_W:0]   A;
  logic [EXP_W+MAN_W:0]   B;
  logic                   out_valid;
  logic [EXP_W-1:0]       exponent_out;
  logic [MAN_W:0]         aligned_result;
  logic                   carry_out;
  logic                   aligned_sign;
  logic [MAN_W:0]         aligned_mantissa_a;
  logic [MAN_W:0]         aligned_mantissa_b;

  modport master (
    output in_valid, A, B,
    input  out_valid, exponent_out, aligned_result, carry_out, aligned_sign,
           aligned_mantissa_a, aligned_mantissa_b
  );

  modport slave (
    input  in_valid, A, B,
    output out_valid, exponent_out, aligned_result, carry_out, aligned_sign,
           aligned_mantissa_a, aligned_mantissa_b
  );
endinterface

// File: rtl/fp_add_front_end.sv
// fp_add_front_end: field masking, exponent alignment and signed mantissa
// add/subtract for binary32 addition, in a 2-stage pipeline.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears both stages
//   bus   : slave side of fp_add_front_end_if (operands in, aligned results out)
// Stage 1 registers the aligned mantissas, signs and common exponent; stage 2
// registers the add/subtract result. Outputs hold while no valid op advances.
module fp_add_front_end #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  fp_add_front_end_if.slave     bus
);

  localparam int M_W  = MAN_W + 1;
  localparam int OP_W = 1 + EXP_W + MAN_W;

  // Right shift that flushes to zero once every mantissa bit is shifted out;
  // no guard/round/sticky bits are kept.
  function automatic logic [M_W-1:0] align_shift(input logic [M_W-1:0] m,
                                                 input logic [EXP_W-1:0] d);
    if (d >= EXP_W'(M_W)) begin
      return '0;
    end else begin
      return m >> d;
    end
  endfunction

  // Stage-1 combinational signals
  logic             sign_a_s, sign_b_s;
  logic [EXP_W-1:0] exp_a_s, exp_b_s, exp_max_s;
  logic [M_W-1:0]   man_a_s, man_b_s, al_a_s, al_b_s;

  // Stage-1 registers
  logic             s1_valid_d, s1_valid_q;
  logic             s1_sign_a_d, s1_sign_a_q, s1_sign_b_d, s1_sign_b_q;
  logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
  logic [M_W-1:0]   s1_ma_d, s1_ma_q, s1_mb_d, s1_mb_q;

  // Stage-2 (output) registers
  logic             out_valid_d, out_valid_q;
  logic [EXP_W-1:0] exp_out_d, exp_out_q;
  logic [M_W-1:0]   result_d, result_q;
  logic             carry_d, carry_q;
  logic             sign_d, sign_q;
  logic [M_W-1:0]   out_ma_d, out_ma_q, out_mb_d, out_mb_q;

  // Stage-2 combinational ALU
  logic [M_W:0]     alu_s;
  logic             alu_sign_s;

  // Field masking and exponent alignment; equal exponents select A.
  always_comb begin
    sign_a_s = bus.A[OP_W-1];
    sign_b_s = bus.B[OP_W-1];
    exp_a_s  = bus.A[OP_W-2 -: EXP_W];
    exp_b_s  = bus.B[OP_W-2 -: EXP_W];
    // Hidden bit is 1 for any nonzero exponent, including all-ones.
    man_a_s  = {(exp_a_s != '0), bus.A[MAN_W-1:0]};
    man_b_s  = {(exp_b_s != '0), bus.B[MAN_W-1:0]};
    if (exp_a_s >= exp_b_s) begin
      exp_max_s = exp_a_s;
      al_a_s    = man_a_s;
      al_b_s    = align_shift(man_b_s, exp_a_s - exp_b_s);
    end else begin
      exp_max_s = exp_b_s;
      al_a_s    = align_shift(man_a_s, exp_b_s - exp_a_s);
      al_b_s    = man_b_s;
    end
  end

  // Stage-1 next state: capture on in_valid, otherwise hold data and drop valid.
  always_comb begin
    s1_valid_d  = bus.in_valid;
    s1_sign_a_d = s1_sign_a_q;
    s1_sign_b_d = s1_sign_b_q;
    s1_exp_d    = s1_exp_q;
    s1_ma_d     = s1_ma_q;
    s1_mb_d     = s1_mb_q;
    if (bus.in_valid) begin
      s1_sign_a_d = sign_a_s;
      s1_sign_b_d = sign_b_s;
      s1_exp_d    = exp_max_s;
      s1_ma_d     = al_a_s;
      s1_mb_d     = al_b_s;
    end else begin
      s1_valid_d  = 1'b0;
    end
  end

  // Signed-magnitude add/subtract; cancellation and ties take A's sign.
  always_comb begin
    alu_s      = '0;
    alu_sign_s = s1_sign_a_q;
    if (s1_sign_a_q == s1_sign_b_q) begin
      alu_s      = {1'b0, s1_ma_q} + {1'b0, s1_mb_q};
      alu_sign_s = s1_sign_a_q;
    end else if (s1_ma_q > s1_mb_q) begin
      alu_s      = {1'b0, s1_ma_q - s1_mb_q};
      alu_sign_s = s1_sign_a_q;
    end else if (s1_mb_q > s1_ma_q) begin
      alu_s      = {1'b0, s1_mb_q - s1_ma_q};
      alu_sign_s = s1_sign_b_q;
    end else begin
      alu_s      = '0;
      alu_sign_s = s1_sign_a_q;
    end
  end

  // Stage-2 next state: outputs update only when a valid op advances.
  always_comb begin
    out_valid_d = s1_valid_q;
    exp_out_d   = exp_out_q;
    result_d    = result_q;
    carry_d     = carry_q;
    sign_d      = sign_q;
    out_ma_d    = out_ma_q;
    out_mb_d    = out_mb_q;
    if (s1_valid_q) begin
      exp_out_d = s1_exp_q;
      result_d  = alu_s[M_W-1:0];
      carry_d   = alu_s[M_W];
      sign_d    = alu_sign_s;
      out_ma_d  = s1_ma_q;
      out_mb_d  = s1_mb_q;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous reset that discards ops in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_a_q <= 1'b0;
      s1_sign_b_q <= 1'b0;
      s1_exp_q    <= '0;
      s1_ma_q     <= '0;
      s1_mb_q     <= '0;
      out_valid_q <= 1'b0;
      exp_out_q   <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      sign_q      <= 1'b0;
      out_ma_q    <= '0;
      out_mb_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_a_q <= s1_sign_a_d;
      s1_sign_b_q <= s1_sign_b_d;
      s1_exp_q    <= s1_exp_d;
      s1_ma_q     <= s1_ma_d;
      s1_mb_q     <= s1_mb_d;
      out_valid_q <= out_valid_d;
      exp_out_q   <= exp_out_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      sign_q      <= sign_d;
      out_ma_q    <= out_ma_d;
      out_mb_q    <= out_mb_d;
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.exponent_out       = exp_out_q;
  assign bus.aligned_result     = result_q;
  assign bus.carry_out          = carry_q;
  assign bus.aligned_sign       = sign_q;
  assign bus.aligned_mantissa_a = out_ma_q;
  assign bus.aligned_mantissa_b = out_mb_q;

endmodule

// File: tb/tb_fp_add_front_end.sv
// tb_fp_add_front_end: directed vector table, reset-in-flight sequence and a
// randomized sweep, all checked against an arithmetic reference model.
module tb_fp_add_front_end;

  logic clk;
  logic reset;

  fp_add_front_end_if bus ();

  fp_add_front_end dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  e;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [23:0] res;
    logic        c;
    logic        s;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  e;
    logic [23:0] ma;
    logic [23:0] mb;
    logic [23:0] res;
    logic        c;
    logic        s;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;

  res_t m_s1;
  logic m_s1_v;
  res_t m_out;
  logic m_out_v;

  // Reference: plain integer arithmetic on the decoded operand values.
  function automatic res_t ref_calc(input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint ea, eb, ma, mb, d, s;
    ea = longint'(a[30:23]);
    eb = longint'(b[30:23]);
    ma = longint'(a[22:0]) + ((ea != 0) ? 64'sd8388608 : 64'sd0);
    mb = longint'(b[22:0]) + ((eb != 0) ? 64'sd8388608 : 64'sd0);
    d  = (ea > eb) ? ea - eb : eb - ea;
    if (ea >= eb) begin
      r.e = 8'(ea);
      mb  = (d >= 24) ? 64'sd0 : mb / (64'sd1 << d);
    end else begin
      r.e = 8'(eb);
      ma  = (d >= 24) ? 64'sd0 : ma / (64'sd1 << d);
    end
    if (a[31] == b[31]) s = ma + mb;
    else                s = (ma > mb) ? ma - mb : mb - ma;
    r.ma  = 24'(ma);
    r.mb  = 24'(mb);
    r.c   = (s >= 64'sd16777216);
    r.res = 24'(s % 64'sd16777216);
    r.s   = (ma > mb) ? a[31] : ((mb > ma) ? b[31] : a[31]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid",      32'(bus.out_valid),          32'(m_out_v));
    chk("exponent_out",   32'(bus.exponent_out),       32'(m_out.e));
    chk("aligned_result", 32'(bus.aligned_result),     32'(m_out.res));
    chk("carry_out",      32'(bus.carry_out),          32'(m_out.c));
    chk("aligned_sign",   32'(bus.aligned_sign),       32'(m_out.s));
    chk("mantissa_a",     32'(bus.aligned_mantissa_a), 32'(m_out.ma));
    chk("mantissa_b",     32'(bus.aligned_mantissa_b), 32'(m_out.mb));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input logic rst_i, input logic v_i,
                      input logic [31:0] a_i, input logic [31:0] b_i);
    res_t nxt;
    reset        = rst_i;
    bus.in_valid = v_i;
    bus.A        = a_i;
    bus.B        = b_i;
    nxt          = ref_calc(a_i, b_i);
    @(posedge clk);
    #1;
    if (rst_i) begin
      m_s1_v  = 1'b0;
      m_s1    = '0;
      m_out_v = 1'b0;
      m_out   = '0;
    end else begin
      if (m_s1_v) m_out = m_s1;
      m_out_v = m_s1_v;
      m_s1    = nxt;
      m_s1_v  = v_i;
    end
    check_model();
  endtask

  vec_t tbl [10];

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  eb;

    tbl[0] = '{32'h3F800000, 32'h40000000, 8'h80, 24'h400000, 24'h800000, 24'hC00000, 1'b0, 1'b0};
    tbl[1] = '{32'h3F800000, 32'h3F800000, 8'h7F, 24'h800000, 24'h800000, 24'h000000, 1'b1, 1'b0};
    tbl[2] = '{32'h40000000, 32'hBF800000, 8'h80, 24'h800000, 24'h400000, 24'h400000, 1'b0, 1'b0};
    tbl[3] = '{32'hBF800000, 32'h40000000, 8'h80, 24'h400000, 24'h800000, 24'h400000, 1'b0, 1'b0};
    tbl[4] = '{32'h3F800000, 32'hBF800000, 8'h7F, 24'h800000, 24'h800000, 24'h000000, 1'b0, 1'b0};
    tbl[5] = '{32'hBF800000, 32'h3F800000, 8'h7F, 24'h800000, 24'h800000, 24'h000000, 1'b0, 1'b1};
    tbl[6] = '{32'h4B800000, 32'h3F800000, 8'h97, 24'h800000, 24'h000000, 24'h800000, 1'b0, 1'b0};
    tbl[7] = '{32'h00000001, 32'h00000001, 8'h00, 24'h000001, 24'h000001, 24'h000002, 1'b0, 1'b0};
    tbl[8] = '{32'h4B000000, 32'h3F800000, 8'h96, 24'h800000, 24'h000001, 24'h800001, 1'b0, 1'b0};
    tbl[9] = '{32'h7F800000, 32'h7F800000, 8'hFF, 24'h800000, 24'h800000, 24'h000000, 1'b1, 1'b0};

    m_s1 = '0; m_s1_v = 1'b0; m_out = '0; m_out_v = 1'b0;
    reset = 1'b1; bus.in_valid = 1'b0; bus.A = 32'h0; bus.B = 32'h0;

    // Reset state, with in_valid asserted to show reset overrides it.
    step(1'b1, 1'b1, 32'h3F800000, 32'h40000000);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);

    // Directed table: one op, then one idle cycle, result after 2 edges.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, tbl[i].a, tbl[i].b);
      chk("tbl_latency_early", 32'(bus.out_valid), 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid),          32'h1);
      chk($sformatf("tbl%0d_exp", i),   32'(bus.exponent_out),       32'(tbl[i].e));
      chk($sformatf("tbl%0d_ma", i),    32'(bus.aligned_mantissa_a), 32'(tbl[i].ma));
      chk($sformatf("tbl%0d_mb", i),    32'(bus.aligned_mantissa_b), 32'(tbl[i].mb));
      chk($sformatf("tbl%0d_res", i),   32'(bus.aligned_result),     32'(tbl[i].res));
      chk($sformatf("tbl%0d_carry", i), 32'(bus.carry_out),          32'(tbl[i].c));
      chk($sformatf("tbl%0d_sign", i),  32'(bus.aligned_sign),       32'(tbl[i].s));
      // Outputs hold while nothing valid advances.
      step(1'b0, 1'b0, 32'h0, 32'h0);
      chk($sformatf("tbl%0d_hold", i),  32'(bus.aligned_result),     32'(tbl[i].res));
    end

    // Back-to-back ops with reset on the second cycle: everything discarded.
    step(1'b0, 1'b1, 32'h3F800000, 32'h40000000);
    step(1'b1, 1'b1, 32'h40000000, 32'h40000000);
    chk("rst_flight_valid", 32'(bus.out_valid),      32'h0);
    chk("rst_flight_exp",   32'(bus.exponent_out),   32'h0);
    chk("rst_flight_res",   32'(bus.aligned_result), 32'h0);
    chk("rst_flight_ma",    32'(bus.aligned_mantissa_a), 32'h0);
    step(1'b0, 1'b1, 32'hBF800000, 32'h3F800000);
    chk("resume_early", 32'(bus.out_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("resume_valid", 32'(bus.out_valid),    32'h1);
    chk("resume_exp",   32'(bus.exponent_out), 32'h7F);
    chk("resume_sign",  32'(bus.aligned_sign), 32'h1);

    // Randomized sweep, biased toward nearby exponents and equal magnitudes.
    for (int i = 0; i < 20000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          eb = ra[30:23] + 8'($urandom_range(0, 60)) - 8'd30;
          rb[30:23] = eb;
        end
        1: rb[30:0] = ra[30:0];
        default: rb = rb;
      endcase
      step(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, ra, rb);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
